// File: rtl/ram_stream_reader.sv
// Read-side master for a 1-cycle-latency synchronous RAM that emits len_i words from base_i as a ready/valid stream.
// Define RAM_STREAM_READER_LAST_EN to add the last_o end-of-transfer tag.
module ram_stream_reader #(
    parameter int width_p = 8,
    parameter int depth_p = 128
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [$clog2(depth_p)-1:0] base_i,
    input  logic [$clog2(depth_p):0]   len_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(depth_p)-1:0] rd_addr_o,
    input  logic [width_p-1:0]         rd_data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [width_p-1:0]         data_o
`ifdef RAM_STREAM_READER_LAST_EN
    ,
    output logic                       last_o
`endif
);
    localparam int addr_w = $clog2(depth_p);

    // state | meaning
    // IDLE  | waiting for start_i
    // RUN   | issuing reads while words remain
    // DRAIN | all reads issued, emptying in-flight read and buffer
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [addr_w-1:0]   ptr_q, ptr_d;
    logic [addr_w:0]     rem_q, rem_d;
    logic                infl_q, issue, pop, done_d, last_issue;
    logic [1:0]          occ_q, occ_d, wr_idx;
    logic [width_p-1:0]  head_q, head_d, tail_q, tail_d;

    assign valid_o    = occ_q != 2'd0;
    assign pop        = valid_o & ready_i;
    assign busy_o     = state_q != IDLE;
    assign rd_addr_o  = ptr_q;
    assign data_o     = head_q;
    assign occ_d      = occ_q - {1'b0, pop} + {1'b0, infl_q};
    assign wr_idx     = occ_q - {1'b0, pop};
    assign last_issue = issue && (rem_q == (addr_w+1)'(1));

    // Credit check counts the read already in flight so the 2-entry buffer can never overflow.
    always_comb begin
        issue = 1'b0;
        if (state_q == RUN && rem_q != '0)
            issue = ({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop)
            head_d = tail_q;
        if (infl_q) begin
            if (wr_idx == 2'd0)
                head_d = rd_data_i;
            else
                tail_d = rd_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        ptr_d   = base_i;
                        rem_d   = len_i;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last_issue)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (occ_d == 2'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            ptr_d = (ptr_q == addr_w'(depth_p - 1)) ? '0 : ptr_q + addr_w'(1);
            rem_d = rem_q - (addr_w+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            infl_q  <= 1'b0;
            occ_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            infl_q  <= issue;
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            done_o  <= done_d;
        end
    end

`ifdef RAM_STREAM_READER_LAST_EN
    logic infl_last_q, head_last_q, tail_last_q, head_last_d, tail_last_d;

    // Tags travel with the data words through the same two buffer slots.
    always_comb begin
        head_last_d = head_last_q;
        tail_last_d = tail_last_q;
        if (pop)
            head_last_d = tail_last_q;
        if (infl_q) begin
            if (wr_idx == 2'd0)
                head_last_d = infl_last_q;
            else
                tail_last_d = infl_last_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            infl_last_q <= 1'b0;
            head_last_q <= 1'b0;
            tail_last_q <= 1'b0;
        end else begin
            infl_last_q <= last_issue;
            head_last_q <= head_last_d;
            tail_last_q <= tail_last_d;
        end
    end

    assign last_o = valid_o & head_last_q;
`endif

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side master for a ram_1r1w_sync instance: drives the RAM read address and consumes its 1-cycle-latency read data.
- On a start command it reads len_i consecutive words from base_i, wrapping modulo depth_p, and emits them as a ready/valid stream.
- Handles downstream backpressure with a 2-entry output buffer and credit-based issue, sustaining 1 word/cycle when ready_i is held high.

Parameters:
- width_p, 8, data word width; must match the RAM.
- depth_p, 128, RAM depth; addresses are $clog2(depth_p) bits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-low reset (0 = reset).
- start_i  input  1  start command; sampled only in IDLE.
- base_i  input  $clog2(depth_p)  first read address; captured with start_i.
- len_i  input  $clog2(depth_p)+1  word count, 0..depth_p; captured with start_i.
- busy_o  output  1  high in RUN and DRAIN.
- done_o  output  1  one-cycle pulse at completion.
- rd_addr_o  output  $clog2(depth_p)  RAM read address.
- rd_data_i  input  width_p  RAM read data for the rd_addr_o presented in the previous cycle.
- valid_o  output  1  stream data valid.
- ready_i  input  1  stream consumer ready.
- data_o  output  width_p  stream data; head of the output buffer.

Behaviour:
- Reset (reset_i=0, asynchronous): state IDLE; busy_o=0, done_o=0, valid_o=0, rd_addr_o=0, data_o=0; buffer emptied; in-flight flag cleared. Any transfer in progress is abandoned without a done_o pulse.
- Definitions:
  - occ = buffer occupancy (0..2).
  - infl = 1 if a read was issued in the previous cycle.
  - pop = valid_o & ready_i.
  - remaining = words not yet issued.
- IDLE:
  - start_i=1 and len_i!=0: capture pointer=base_i and remaining=len_i; go to RUN next cycle.
  - start_i=1 and len_i==0: done_o pulses the next cycle; stay in IDLE.
  - start_i=0: no action.
- RUN:
  - rd_addr_o = pointer.
  - Issue occurs when remaining!=0 and (occ + infl - pop) < 2.
  - On issue: pointer <= (pointer==depth_p-1) ? 0 : pointer+1; remaining decrements; infl next cycle = 1.
  - When remaining reaches 0, go to DRAIN.
- Capture: when infl=1, rd_data_i is written to the buffer tail at the clock edge.
  - Buffer overflow is impossible by the issue rule; this is an assertion target for verification.
- Output: valid_o = (occ != 0); data_o = buffer head.
  - data_o holds stable while valid_o=1 and ready_i=0.
  - valid_o never deasserts without a pop.
- DRAIN:
  - No issues.
  - When occ==0 and infl==0, including the pop cycle of the last word: go to IDLE and assert done_o for one cycle; busy_o falls that same cycle.
- Latency: start accepted at cycle T → first issue at T+1 → first valid_o at T+3.
  - With ready_i=1 throughout, N words occupy valid_o during T+3..T+N+2.
  - done_o pulses at T+N+3.
- rd_addr_o holds its last value when not issuing. The RAM is read every cycle, so only issued cycles are captured.
- start_i outside IDLE is ignored; base_i and len_i are don't-care then.
- len_i==depth_p reads every word exactly once, finishing at base_i-1 mod depth_p.

Optional Feature:
- Macro: RAM_STREAM_READER_LAST_EN.
- Defined:
  - Adds output port last_o (1 bit), tagged per buffer entry.
  - last_o=1 exactly while valid_o=1 and data_o is the final word of the transfer.
  - Reset value is 0.
  - A len_i==0 transfer produces no beat, so no last_o.
- Undefined: last_o port and its tag storage are absent; all other behaviour is identical.

Test Plan:
- Basic burst: RAM preloaded mem[a]=a. start with base=5, len=4, ready_i=1 → data_o 5,6,7,8 on consecutive cycles T+3..T+6; done_o at T+7; busy_o high T+1..T+6.
- Wrap-around: depth_p=128, base=126, len=4 → 126,127,0,1; with LAST_EN, last_o=1 only on word 1.
- Backpressure: len=6, ready_i toggled 1,0,0,1,0,1,... → all 6 words delivered in order with none lost or duplicated; data_o stable while stalled; buffer never holds more than 2 words.
- Zero and full length:
  - len=0 → done_o pulses the next cycle with no valid_o.
  - len=128 from base=64 → words 64..127,0..63 in order.
- Start during busy and reset mid-op:
  - start_i pulsed during RUN with a different base → ignored.
  - reset_i=0 mid-burst → valid_o, busy_o and done_o drop immediately.
  - A subsequent start runs cleanly from its own base.
